// File: rtl/icache_pkg.sv
// Instruction cache geometry, line record and refill FSM states.
// ICACHE_PREFETCH_EN adds the next-line prefetch states.
package icache_pkg;

  import sys_defs::*;

  localparam int ICACHE_LINES = 32;
  localparam int LINE_BYTES   = 8;
  localparam int OFF_W        = 3;
  localparam int IDX_W        = $clog2(ICACHE_LINES);
  localparam int LINE_W       = XLEN - OFF_W;
  localparam int TAG_W        = LINE_W - IDX_W;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [63:0]      data;
  } icache_line_t;

`ifdef ICACHE_PREFETCH_EN
  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    PF_REQ,
    PF_WAIT
  } icache_state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } icache_state_t;
`endif

  function automatic logic [LINE_W-1:0] line_of(
    input logic [XLEN-1:0] a
  );
    return a[XLEN-1:OFF_W];
  endfunction

endpackage

// File: rtl/sys_defs.sv
// Shared system definitions: data path width and memory bus commands.
// Common to all units that talk to the cache controller.
package sys_defs;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_command_t;

endpackage

// File: rtl/icache_mem.sv
// Direct-mapped line array: async read, sync single-port write.
// ICACHE_PREFETCH_EN adds a second read port for next-line lookup.
module icache_mem
  import icache_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output icache_line_t     rd_line,
`ifdef ICACHE_PREFETCH_EN
  input  logic [IDX_W-1:0] pf_idx,
  output icache_line_t     pf_line,
`endif
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [63:0]      wr_data
);

  logic [ICACHE_LINES-1:0] valid;
  logic [TAG_W-1:0]        tags [ICACHE_LINES];
  logic [63:0]             data [ICACHE_LINES];

  // valid bits are the only state that needs clearing
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // tag and data storage, written on fill
  always_ff @(posedge clock) begin
    if (wr_en) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_data;
    end
  end

  assign rd_line = '{
    valid: valid[rd_idx],
    tag:   tags[rd_idx],
    data:  data[rd_idx]
  };

`ifdef ICACHE_PREFETCH_EN
  assign pf_line = '{
    valid: valid[pf_idx],
    tag:   tags[pf_idx],
    data:  data[pf_idx]
  };
`endif

endmodule

// File: rtl/icache_fill_unit.sv
// Direct-mapped icache with single-outstanding-miss refill.
// ICACHE_PREFETCH_EN enables next-line prefetch after demand fills.
module icache_fill_unit
  import sys_defs::*;
  import icache_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] proc2Icache_addr,
  output logic [63:0]     Icache_data_out,
  output logic            Icache_valid_out,
  output logic [1:0]      Icache2ctrl_command,
  output logic [XLEN-1:0] Icache2ctrl_addr,
  input  logic [3:0]      ctrl2Icache_response,
  input  logic [63:0]     ctrl2Icache_data,
  input  logic [3:0]      ctrl2Icache_tag
);

  icache_state_t     state, state_n;
  logic [LINE_W-1:0] miss_line, miss_line_n;
  logic [3:0]        txn_tag, txn_tag_n;
  logic [LINE_W-1:0] fetch_line;
  logic [LINE_W-1:0] req_line;
  bus_command_t      cmd;
  icache_line_t      rd_line;
  logic              hit;
  logic              moved;
  logic              tag_done;
  logic              fill_en;
  logic              unused_off;

  assign fetch_line = line_of(proc2Icache_addr);
  assign unused_off = ^proc2Icache_addr[OFF_W-1:0];

  assign hit = rd_line.valid &&
               rd_line.tag == fetch_line[LINE_W-1:IDX_W];
  assign moved    = fetch_line != miss_line;
  assign tag_done = |txn_tag && ctrl2Icache_tag == txn_tag;

  assign Icache_valid_out    = hit;
  assign Icache_data_out     = hit ? rd_line.data : '0;
  assign Icache2ctrl_command = cmd;
  assign Icache2ctrl_addr    = {req_line, {OFF_W{1'b0}}};

`ifdef ICACHE_PREFETCH_EN
  logic [LINE_W-1:0] next_line;
  icache_line_t      pf_line;
  logic              next_present;

  assign next_line    = miss_line + LINE_W'(1);
  assign next_present = pf_line.valid &&
                        pf_line.tag == next_line[LINE_W-1:IDX_W];
`endif

  icache_mem u_mem (
    .clock   (clock),
    .reset   (reset),
    .rd_idx  (fetch_line[IDX_W-1:0]),
    .rd_line (rd_line),
`ifdef ICACHE_PREFETCH_EN
    .pf_idx  (next_line[IDX_W-1:0]),
    .pf_line (pf_line),
`endif
    .wr_en   (fill_en),
    .wr_idx  (miss_line[IDX_W-1:0]),
    .wr_tag  (miss_line[LINE_W-1:IDX_W]),
    .wr_data (ctrl2Icache_data)
  );

  // state and miss bookkeeping; reset drops any in-flight fill
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      miss_line <= '0;
      txn_tag   <= '0;
    end else begin
      state     <= state_n;
      miss_line <= miss_line_n;
      txn_tag   <= txn_tag_n;
    end
  end

  // next state: latch misses, retry until accepted, wait for tag
  always_comb begin
    state_n     = state;
    miss_line_n = miss_line;
    txn_tag_n   = txn_tag;
    unique case (state)
      IDLE: begin
        if (!hit) begin
          miss_line_n = fetch_line;
          state_n     = REQ;
        end
      end
      REQ: begin
        if (moved && hit) begin
          state_n = IDLE;
        end else begin
          if (moved) miss_line_n = fetch_line;
          if (|ctrl2Icache_response) begin
            txn_tag_n = ctrl2Icache_response;
            state_n   = WAIT;
          end
        end
      end
      WAIT: begin
        if (tag_done) begin
          txn_tag_n = '0;
          state_n   = IDLE;
`ifdef ICACHE_PREFETCH_EN
          if (!next_present) begin
            miss_line_n = next_line;
            state_n     = PF_REQ;
          end
`endif
        end
      end
`ifdef ICACHE_PREFETCH_EN
      PF_REQ: begin
        if (!hit) begin
          miss_line_n = fetch_line;
          state_n     = REQ;
        end else if (|ctrl2Icache_response) begin
          txn_tag_n = ctrl2Icache_response;
          state_n   = PF_WAIT;
        end
      end
      PF_WAIT: begin
        if (tag_done) begin
          txn_tag_n = '0;
          state_n   = IDLE;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // bus request and fill strobe
  always_comb begin
    cmd      = BUS_NONE;
    req_line = '0;
    fill_en  = 1'b0;
    unique case (state)
      REQ: begin
        if (!(moved && hit)) begin
          cmd      = BUS_LOAD;
          req_line = moved ? fetch_line : miss_line;
        end
      end
      WAIT: fill_en = tag_done;
`ifdef ICACHE_PREFETCH_EN
      PF_REQ: begin
        if (hit) begin
          cmd      = BUS_LOAD;
          req_line = miss_line;
        end
      end
      PF_WAIT: fill_en = tag_done;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_icache_fill_unit.sv
// Scoreboard bench for icache_fill_unit.
// Build with ICACHE_PREFETCH_EN to run the prefetch sequence.
module tb_icache_fill_unit;

  import sys_defs::*;

  localparam logic [63:0] D1 = 64'hDEADBEEF_CAFEF00D;
  localparam logic [63:0] D2 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D3 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] DJ = 64'h0BAD_0BAD_0BAD_0BAD;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr  = '0;
  logic [3:0]  resp  = '0;
  logic [3:0]  rtag  = '0;
  logic [63:0] rdata = '0;
  logic [63:0] data_out;
  logic        valid_out;
  logic [1:0]  cmd;
  logic [31:0] req_addr;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  logic [31:0] req_q [$];
  logic [63:0] hit_q [$];
  logic [31:0] ea;
  logic [63:0] ed;

  always #5 clock = ~clock;

  icache_fill_unit dut (
    .clock                (clock),
    .reset                (reset),
    .proc2Icache_addr     (addr),
    .Icache_data_out      (data_out),
    .Icache_valid_out     (valid_out),
    .Icache2ctrl_command  (cmd),
    .Icache2ctrl_addr     (req_addr),
    .ctrl2Icache_response (resp),
    .ctrl2Icache_data     (rdata),
    .ctrl2Icache_tag      (rtag)
  );

  // drive one cycle and post what the monitor must see in it
  task automatic cyc(
    input logic [31:0] a,
    input logic [3:0]  rs,
    input logic [3:0]  tg,
    input logic [63:0] d,
    input bit          er,
    input logic [31:0] ea_i,
    input bit          eh,
    input logic [63:0] ed_i
  );
    addr  = a;
    resp  = rs;
    rtag  = tg;
    rdata = d;
    if (er) req_q.push_back(ea_i);
    if (eh) hit_q.push_back(ed_i);
    @(posedge clock);
    #1;
  endtask

  task automatic chk(
    input string       name,
    input logic [63:0] got,
    input logic [63:0] want
  );
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // monitor: compare bus requests and hits against the scoreboard
  always @(negedge clock) begin
    if (mon_en) begin
      if (cmd == BUS_LOAD || req_q.size() != 0) begin
        checks++;
        if (req_q.size() == 0) begin
          failures++;
          $display("FAIL req_unexpected addr=%h", req_addr);
        end else begin
          ea = req_q.pop_front();
          if (cmd !== BUS_LOAD || req_addr !== ea) begin
            failures++;
            $display("FAIL req got cmd=%0d addr=%h want cmd=1 addr=%h",
                     cmd, req_addr, ea);
          end
        end
      end
      if (valid_out || hit_q.size() != 0) begin
        checks++;
        if (hit_q.size() == 0) begin
          failures++;
          $display("FAIL hit_unexpected addr=%h data=%h", addr, data_out);
        end else begin
          ed = hit_q.pop_front();
          if (valid_out !== 1'b1 || data_out !== ed) begin
            failures++;
            $display("FAIL hit addr=%h got v=%b d=%h want v=1 d=%h",
                     addr, valid_out, data_out, ed);
          end
        end
      end else begin
        checks++;
        if (data_out !== 64'h0) begin
          failures++;
          $display("FAIL miss_data got=%h want=0", data_out);
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("rst_valid", {63'h0, valid_out}, 64'h0);
    chk("rst_data",  data_out, 64'h0);
    chk("rst_cmd",   {62'h0, cmd}, 64'h0);
    chk("rst_addr",  {32'h0, req_addr}, 64'h0);
    reset  = 1'b1;
    mon_en = 1'b1;

`ifdef ICACHE_PREFETCH_EN
    cyc(32'h100, 0, 0, '0, 0, '0, 0, '0);
    cyc(32'h100, 1, 0, '0, 1, 32'h100, 0, '0);
    cyc(32'h100, 0, 1, D1, 0, '0, 0, '0);
    cyc(32'h100, 2, 0, '0, 1, 32'h108, 1, D1);
    cyc(32'h100, 0, 2, D3, 0, '0, 1, D1);
    cyc(32'h108, 0, 0, '0, 0, '0, 1, D3);
    cyc(32'h100, 0, 0, '0, 0, '0, 1, D1);
`else
    // cold miss, accepted at once, tag 4 cycles later, no bypass
    cyc(32'h104, 0, 0, '0, 0, '0, 0, '0);
    cyc(32'h104, 3, 0, '0, 1, 32'h100, 0, '0);
    repeat (3) cyc(32'h104, 0, 0, '0, 0, '0, 0, '0);
    cyc(32'h104, 0, 3, D1, 0, '0, 0, '0);
    cyc(32'h104, 0, 0, '0, 0, '0, 1, D1);
    cyc(32'h100, 0, 0, '0, 0, '0, 1, D1);

    // conflicting tag at index 0, five rejects, stray tag ignored
    cyc(32'h200, 0, 0, '0, 0, '0, 0, '0);
    repeat (5) cyc(32'h200, 0, 0, '0, 1, 32'h200, 0, '0);
    cyc(32'h200, 2, 0, '0, 1, 32'h200, 0, '0);
    cyc(32'h200, 0, 5, DJ, 0, '0, 0, '0);
    cyc(32'h200, 0, 2, D2, 0, '0, 0, '0);
    cyc(32'h200, 0, 0, '0, 0, '0, 1, D2);

    // old line evicted; fetch moves to 0x108 before acceptance
    cyc(32'h100, 0, 0, '0, 0, '0, 0, '0);
    cyc(32'h100, 0, 0, '0, 1, 32'h100, 0, '0);
    cyc(32'h108, 0, 0, '0, 1, 32'h108, 0, '0);
    cyc(32'h108, 4, 0, '0, 1, 32'h108, 0, '0);
    cyc(32'h108, 0, 4, D3, 0, '0, 0, '0);
    cyc(32'h108, 0, 0, '0, 0, '0, 1, D3);
    cyc(32'h100, 0, 0, '0, 0, '0, 0, '0);
    cyc(32'h100, 0, 0, '0, 1, 32'h100, 0, '0);
    cyc(32'h108, 0, 0, '0, 0, '0, 1, D3);
    cyc(32'h108, 0, 0, '0, 0, '0, 1, D3);

    // reset while waiting; late tag must not fill
    cyc(32'h300, 0, 0, '0, 0, '0, 0, '0);
    cyc(32'h300, 6, 0, '0, 1, 32'h300, 0, '0);
    cyc(32'h300, 0, 0, '0, 0, '0, 0, '0);
    reset = 1'b0;
    cyc(32'h300, 0, 0, '0, 0, '0, 0, '0);
    reset = 1'b1;
    cyc(32'h300, 0, 6, DJ, 0, '0, 0, '0);
    cyc(32'h300, 0, 6, DJ, 1, 32'h300, 0, '0);
    cyc(32'h108, 0, 0, '0, 1, 32'h108, 0, '0);
    cyc(32'h108, 0, 0, '0, 1, 32'h108, 0, '0);
`endif

    mon_en = 1'b0;
    chk("req_q_drained", 64'(req_q.size()), 64'h0);
    chk("hit_q_drained", 64'(hit_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache_fill_unit.md
Name: icache_fill_unit

Overview:
- Direct-mapped instruction cache with single-outstanding-miss refill logic.
- Sits directly upstream of the cache controller's Icache port: serves fetch lookups, and on a miss issues BUS_LOAD and absorbs the tagged memory response.
- Handles rejected requests (controller grants Dcache priority) by holding and retrying.

Parameters:
ICACHE_LINES, 32, number of 8-byte lines; power of 2; index width IDX_W = log2(ICACHE_LINES).
LINE_BYTES, 8, fixed line size (64-bit bus beat); offset width 3.

Ports:
clock  input  1  system clock.
reset  input  1  asynchronous, active-low reset.
proc2Icache_addr  input  XLEN  fetch byte address; bits [2:0] ignored.
Icache_data_out  output  64  line data for proc2Icache_addr.
Icache_valid_out  output  1  data valid (hit) this cycle.
Icache2ctrl_command  output  2  BUS_NONE / BUS_LOAD.
Icache2ctrl_addr  output  XLEN  line-aligned request address (bits [2:0] = 0).
ctrl2Icache_response  input  4  transaction tag; nonzero = request accepted this cycle.
ctrl2Icache_data  input  64  returned line data.
ctrl2Icache_tag  input  4  tag of data on ctrl2Icache_data; 0 = nothing returned.

Behaviour:
- Address split: offset [2:0], index [IDX_W+2:3], tag [XLEN-1:IDX_W+3].
- Hit path is combinational: Icache_valid_out = valid[index] && tag match. Icache_data_out = array data, or 0 when not valid.
- Reset (reset low, async): all valid bits 0, state IDLE, saved tag 0, command BUS_NONE, addr 0. Outputs Icache_valid_out = 0 and Icache_data_out = 0.
- Reset mid-miss drops the transaction; a later tag return is ignored.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - On a miss, latch miss address and go to REQ.
  - The request is driven in REQ starting the next cycle.
- REQ:
  - Drive BUS_LOAD with the latched line address.
  - Response 0: stay in REQ and retry next cycle; command stays asserted.
  - Response nonzero: save it as the transaction tag and go to WAIT.
  - If proc2Icache_addr moves to a different line before acceptance:
    - Re-latch the new address when it misses, updating the request the same cycle.
    - Return to IDLE when it hits.
- WAIT:
  - Drive BUS_NONE.
  - When ctrl2Icache_tag == saved tag (nonzero), write data, tag and valid into the latched index and go to IDLE.
  - Icache_valid_out goes high the following cycle if the address is unchanged; there is no same-cycle bypass.
  - A fetch-address change during WAIT does not abort: the fill completes, then a new miss is serviced.
- Tag match in REQ is ignored, because the tag cannot be returned before acceptance.
- A fill overwrites any previous line at that index (no victim writeback; read-only).
- Minimum miss latency: 1 (IDLE) + 1 accepting REQ cycle + memory latency + 1.

Optional Feature:
ICACHE_PREFETCH_EN:
- Defined: after a demand fill completes, if line+1 (address + 8, wraps modulo 2^XLEN) is not valid, enter PF_REQ, then PF_WAIT, with identical retry and tag rules.
- A demand miss while in PF_REQ aborts the prefetch, going straight to REQ.
- A demand miss while in PF_WAIT waits for the prefetch fill, then proceeds.
- Undefined: no prefetch states; FSM is IDLE/REQ/WAIT only.

Decomposition:
- Package icache_pkg holds:
  - ICACHE_LINES, derived IDX_W / TAG_W localparams.
  - typedef icache_line_t {valid, tag, data[63:0]}.
  - enum icache_state_t.
- BUS_NONE / BUS_LOAD come from sys_defs.
- One sub-module: icache_mem (line array with async read and synchronous single-port write, valid clear on reset).

Test Plan:
- Reset, then addr 0x100 -> Icache_valid_out 0 and Icache_data_out 0; next cycle BUS_LOAD at addr 0x100.
- Cold miss 0x104, response 3, then 4 cycles later tag 3 with data 0xDEADBEEF_CAFEF00D:
  - Fill occurs.
  - Next cycle Icache_valid_out 1 with that data.
- Response held 0 for 5 cycles -> BUS_LOAD at 0x100 stays asserted unchanged all 5 cycles; accepted on cycle 6.
- Address 0x100 to 0x108 while in REQ (unaccepted) -> request address switches to 0x108; no fill for 0x100.
- In WAIT on tag 2, ctrl2Icache_tag = 5 arrives first -> ignored; tag 2 then fills. Same-index conflicting tag (0x100 vs 0x200 with 32 lines) evicts the old line.
- Reset asserted in WAIT, tag returned after release -> array stays invalid; ICACHE_PREFETCH_EN: fill 0x100 is followed by BUS_LOAD 0x108.
